// File: rtl/logc_pkg.sv
// +--------------------------------------------------------------------------+
// | logc_pkg : shared widths, log-code type and antilog correction table     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package logc_pkg;

  localparam int DATA_WIDTH  = 48;
  localparam int FRAC_WIDTH  = 16;
  localparam int NORM_WIDTH  = FRAC_WIDTH + 1;
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);
  localparam int LUT_BITS    = 5;
  localparam int CORR_Q      = 16;

  // corr[k] = round(((1 + k/32) - 2^(k/32)) * 2^16): gap between the linear
  // segment and the true exponential at each segment start.
  localparam logic [CORR_Q-1:0] CORR_TABLE [2**LUT_BITS] = '{
    16'd0,    16'd613,  16'd1194, 16'd1744, 16'd2260, 16'd2744, 16'd3192, 16'd3606,
    16'd3984, 16'd4326, 16'd4630, 16'd4895, 16'd5122, 16'd5309, 16'd5456, 16'd5560,
    16'd5622, 16'd5641, 16'd5615, 16'd5543, 16'd5426, 16'd5261, 16'd5047, 16'd4784,
    16'd4470, 16'd4105, 16'd3686, 16'd3214, 16'd2686, 16'd2103, 16'd1461, 16'd761
  };

  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] int_part;
    logic [NORM_WIDTH-1:0]  frac;
  } log_code_t;

endpackage

`default_nettype wire

// File: rtl/antilog_corr_lut.sv
// +--------------------------------------------------------------------------+
// | antilog_corr_lut : combinational ROM, segment index -> mantissa correction |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module antilog_corr_lut
  import logc_pkg::*;
#(
  parameter int FRAC_WIDTH = logc_pkg::FRAC_WIDTH,
  parameter int LUT_BITS   = logc_pkg::LUT_BITS
) (
  input  logic [LUT_BITS-1:0]   idx,
  output logic [FRAC_WIDTH-1:0] corr
);

  // Table is stored in Q16; rescale to the configured fraction width.
  generate
    if (FRAC_WIDTH >= CORR_Q) begin : g_scale_up
      assign corr = FRAC_WIDTH'(CORR_TABLE[idx]) << (FRAC_WIDTH - CORR_Q);
    end else begin : g_scale_down
      assign corr = FRAC_WIDTH'(CORR_TABLE[idx] >> (CORR_Q - FRAC_WIDTH));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/antilog_decomp.sv
// +--------------------------------------------------------------------------+
// | antilog_decomp : 3-stage log2-code to linear magnitude reconstruction    |
// | Optional: ANTILOG_ROUND_EN selects round-half-up on right shifts.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module antilog_decomp
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH  = logc_pkg::DATA_WIDTH,
  parameter int FRAC_WIDTH  = logc_pkg::FRAC_WIDTH,
  parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int LUT_BITS    = logc_pkg::LUT_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] comp_int,
  input  logic [NORM_WIDTH-1:0]  comp_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   sat
);

  localparam int EW = SHIFT_WIDTH + 1;

  logic                  en;
  logic                  s1_valid, s2_valid;
  logic [EW-1:0]         s1_e, s2_e, e_n;
  logic [FRAC_WIDTH-1:0] s1_f, f_n, corr;
  logic [NORM_WIDTH-1:0] s2_m, m_n;
  logic [DATA_WIDTH:0]   m_ext;
  logic [EW-1:0]         rsh;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  sat_n;
`ifdef ANTILOG_ROUND_EN
  logic [DATA_WIDTH:0]   rnd;
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: a set unity bit carries into the exponent; widened e cannot wrap.
  always_comb begin
    e_n = {1'b0, comp_int};
    f_n = comp_frac[FRAC_WIDTH-1:0];
    if (comp_frac[FRAC_WIDTH]) begin
      e_n = {1'b0, comp_int} + EW'(1);
      f_n = '0;
    end
  end

  antilog_corr_lut #(
    .FRAC_WIDTH (FRAC_WIDTH),
    .LUT_BITS   (LUT_BITS)
  ) u_corr_lut (
    .idx  (s1_f[FRAC_WIDTH-1 -: LUT_BITS]),
    .corr (corr)
  );

  // S2: 2^FRAC_WIDTH + f is just the hidden one concatenated on top of f.
  assign m_n   = {1'b1, s1_f} - {1'b0, corr};
  assign m_ext = (DATA_WIDTH+1)'(s2_m);

  always_comb begin
    data_n = '0;
    sat_n  = 1'b0;
    rsh    = EW'(FRAC_WIDTH) - s2_e;
`ifdef ANTILOG_ROUND_EN
    rnd    = '0;
`endif
    if (s2_e >= EW'(DATA_WIDTH)) begin
      data_n = '1;
      sat_n  = 1'b1;
    end else if (s2_e >= EW'(FRAC_WIDTH)) begin
      data_n = DATA_WIDTH'(m_ext << (s2_e - EW'(FRAC_WIDTH)));
    end else begin
`ifdef ANTILOG_ROUND_EN
      rnd    = (DATA_WIDTH+1)'(1) << (rsh - EW'(1));
      data_n = DATA_WIDTH'((m_ext + rnd) >> rsh);
`else
      data_n = DATA_WIDTH'(m_ext >> rsh);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_e      <= '0;
      s1_f      <= '0;
      s2_valid  <= 1'b0;
      s2_e      <= '0;
      s2_m      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_e      <= e_n;
      s1_f      <= f_n;
      s2_valid  <= s1_valid;
      s2_e      <= s1_e;
      s2_m      <= m_n;
      out_valid <= s2_valid;
      data_out  <= data_n;
      sat       <= sat_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_antilog_decomp.sv
// +--------------------------------------------------------------------------+
// | tb_antilog_decomp : bench for antilog_decomp against a real-math model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_antilog_decomp;
  import logc_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int FW = FRAC_WIDTH;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [SHIFT_WIDTH-1:0] comp_int;
  logic [NORM_WIDTH-1:0]  comp_frac;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          data_out;
  logic                   sat;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  antilog_decomp dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comp_int  (comp_int),
    .comp_frac (comp_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat       (sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: 2^(e + f/2^FW) approximated by the segment rule, using real math.
  function automatic exp_t model(input log_code_t c);
    exp_t            r;
    int              e;
    int              sh;
    longint unsigned f, k, corr, m;
    real             t;
    if (c.frac[FW]) begin
      e = int'(c.int_part) + 1;
      f = 0;
    end else begin
      e = int'(c.int_part);
      f = longint'(c.frac[FW-1:0]);
    end
    k    = f >> (FW - LUT_BITS);
    t    = real'(k) / real'(1 << LUT_BITS);
    corr = longint'($rtoi($floor(((1.0 + t) - $pow(2.0, t)) * real'(1 << FW) + 0.5)));
    m    = (longint'(1) << FW) + f - corr;
    r.sat = 1'b0;
    if (e >= DW) begin
      r.data = {DW{1'b1}};
      r.sat  = 1'b1;
    end else if (e >= FW) begin
      r.data = DW'(m << (e - FW));
    end else begin
      sh = FW - e;
`ifdef ANTILOG_ROUND_EN
      r.data = DW'((m + (longint'(1) << (sh - 1))) >> sh);
`else
      r.data = DW'(m >> sh);
`endif
    end
    return r;
  endfunction

  function automatic log_code_t rand_code();
    log_code_t c;
    c.int_part = SHIFT_WIDTH'($urandom_range(0, (1 << SHIFT_WIDTH) - 1));
    case ($urandom % 6)
      0:       c.frac = NORM_WIDTH'(1 << FW);
      1:       c.frac = NORM_WIDTH'($urandom);
      default: c.frac = {1'b0, FW'($urandom)};
    endcase
    return c;
  endfunction

  function automatic log_code_t mk(input int ci, input int cf);
    log_code_t c;
    c.int_part = SHIFT_WIDTH'(ci);
    c.frac     = NORM_WIDTH'(cf);
    return c;
  endfunction

  // Drive on the falling edge, then settle so handshakes can be evaluated.
  task automatic drive(input bit v, input log_code_t c, input bit rdy);
    @(negedge clk);
    in_valid  = v;
    comp_int  = c.int_part;
    comp_frac = c.frac;
    out_ready = rdy;
    #1;
  endtask

  task automatic run_single(input string tag, input log_code_t c,
                            input logic [DW-1:0] ref_data, input logic ref_sat);
    exp_t e;
    int   lat;
    e = model(c);
    drive(1'b1, c, 1'b1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    drive(1'b0, c, 1'b1);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_data"}, 64'(data_out), 64'(ref_data));
    check({tag, "_sat"}, 64'(sat), 64'(ref_sat));
    check({tag, "_model"}, 64'(data_out), 64'(e.data));
  endtask

  initial begin
    log_code_t cur;
    exp_t      got;
    int        sent;
    int        recv;
    int        cyc;
    bit        v;

    reset     = 1'b1;
    in_valid  = 1'b0;
    comp_int  = '0;
    comp_frac = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_sat", 64'(sat), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    run_single("i16_f0", mk(16, 'h00000), 48'd65536, 1'b0);
    run_single("i17_fhalf", mk(17, 'h08000), 48'd185364, 1'b0);
    run_single("i0_f0", mk(0, 'h00000), 48'd1, 1'b0);
    run_single("i47_carry", mk(47, 'h10000), 48'hFFFF_FFFF_FFFF, 1'b1);
    run_single("i63_fmax", mk(63, 'h0FFFF), 48'hFFFF_FFFF_FFFF, 1'b1);
    run_single("i63_carry", mk(63, 'h10000), 48'hFFFF_FFFF_FFFF, 1'b1);
    run_single("i15_fhalf", mk(15, 'h08000), 48'd46341, 1'b0);
`ifdef ANTILOG_ROUND_EN
    run_single("i2_fquarter", mk(2, 'h04000), 48'd5, 1'b0);
`else
    run_single("i2_fquarter", mk(2, 'h04000), 48'd4, 1'b0);
`endif

    // Flush with three codes in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(20 + i, 'h01234), 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_data_out", 64'(data_out), 64'd0);
    check("flush_sat", 64'(sat), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    run_single("after_flush", mk(18, 'h00000), 48'd262144, 1'b0);

    // Random stream with bubbles and random back-pressure.
    sent = 0;
    recv = 0;
    cyc  = 0;
    cur  = rand_code();
    while ((sent < 30 || sb.size() > 0) && cyc < 3000) begin
      v = (sent < 30) && ($urandom % 4 != 0);
      drive(v, cur, ($urandom % 3) != 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stream_extra_output", 64'd1, 64'd0);
        end else begin
          got = sb.pop_front();
          check("stream_data", 64'(data_out), 64'(got.data));
          check("stream_sat", 64'(sat), 64'(got.sat));
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(cur));
        sent++;
        cur = rand_code();
      end
      @(posedge clk);
      cyc++;
    end
    check("stream_no_timeout", 64'(cyc < 3000), 64'd1);
    check("stream_recv_count", 64'(recv), 64'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/antilog_decomp.md
Name: antilog_decomp

Overview:
- Inverse of the log-compression path: takes the (comp_int, comp_frac) log2 code and rebuilds the linear magnitude on DATA_WIDTH bits.
- Sits downstream of storage/transport of compressed samples.
- Feeds linear-domain consumers (scan conversion, compounding) and closes the loop in log compressor round-trip checks.
- 3-stage valid/ready pipeline.

Parameters:
- DATA_WIDTH, 48, width of the reconstructed linear output.
- FRAC_WIDTH, 16, fractional bits of the log code.
- NORM_WIDTH, FRAC_WIDTH+1, width of comp_frac; the top bit is the carry/unity bit.
- SHIFT_WIDTH, $clog2(DATA_WIDTH), width of comp_int.
- LUT_BITS, 5, index bits of the correction LUT (2^LUT_BITS entries).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  log code present.
- in_ready  out  1  block accepts the code this cycle.
- comp_int  in  SHIFT_WIDTH  integer part of log2.
- comp_frac  in  NORM_WIDTH  fractional part of log2, unsigned Q1.FRAC_WIDTH.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts.
- data_out  out  DATA_WIDTH  reconstructed linear value.
- sat  out  1  data_out was saturated; qualified by out_valid.

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: out_valid=0, data_out=0, sat=0, all stage valids 0. in_ready=1 in the cycle after reset deasserts.
- Pipeline advance: en = !out_valid || out_ready. in_ready = en, combinational from out_ready and out_valid. A transfer happens when in_valid && in_ready.
- Latency is 3 cycles from accept to out_valid, with no stall. Throughput is 1 code/cycle.
- While out_valid && !out_ready, all stages and data_out hold. No code is dropped or duplicated.
- A bubble (in_valid=0 while en=1) propagates as an invalid stage.
- S1, normalise:
  - If comp_frac[FRAC_WIDTH]=1, then e = comp_int+1 and f = 0.
  - Otherwise e = comp_int and f = comp_frac[FRAC_WIDTH-1:0].
  - e is SHIFT_WIDTH+1 bits wide.
  - Register e and f.
- S2, mantissa:
  - m = 2^FRAC_WIDTH + f − corr[f[FRAC_WIDTH-1 -: LUT_BITS]], unsigned on NORM_WIDTH bits.
  - corr[k] = round(((1+k/2^LUT_BITS) − 2^(k/2^LUT_BITS))·2^FRAC_WIDTH), so corr[0]=0.
  - m is exact at segment starts. Max relative error is ≤1.3% at LUT_BITS=5.
  - Register m and e.
- S3, shift:
  - If e ≥ DATA_WIDTH: data_out = all ones, sat=1.
  - Else if e ≥ FRAC_WIDTH: data_out = m << (e−FRAC_WIDTH), sat=0.
  - Else: data_out = m >> (FRAC_WIDTH−e), truncating, sat=0.
  - No intermediate overflow: the shift is done on DATA_WIDTH+1 bits. e = DATA_WIDTH−1 with max m fits.
- Boundaries:
  - comp_int=0 with f=0 gives 1. This is the minimum nonzero output.
  - The unity carry at the maximum comp_int wraps into e correctly because e is widened, and the result saturates.
  - Reset asserted mid-stream flushes every stage in the same edge. Codes in flight are lost and out_valid=0 next cycle.
  - Simultaneous accept and output handoff is allowed every cycle.

Optional Feature:
- Macro: ANTILOG_ROUND_EN.
- Defined: in the right-shift case (e < FRAC_WIDTH), round-half-up. Add 1<<(FRAC_WIDTH−e−1) before the shift. The rounding adder lives in S3 and latency is unchanged.
- Undefined: truncate.
- The left-shift and saturation cases are identical either way.

Decomposition:
- Shared package logc_pkg holds:
  - DATA_WIDTH/FRAC_WIDTH/NORM_WIDTH/SHIFT_WIDTH defaults, shared with top_logc.
  - LUT_BITS.
  - Correction table constants, generated, 32×FRAC_WIDTH.
  - Typedef for the log code struct {int, frac}.
- Sub-module antilog_corr_lut: combinational ROM, index in → corr out. Instantiated in S2 and reusable by a future compressor refinement.

Test Plan:
- int=16, frac=0 → data_out=65536, sat=0, out_valid exactly 3 cycles after accept.
- int=17, frac=0x08000 → m=92682, data_out=185364; also int=0, frac=0 → 1.
- int=47, frac=0x10000 → carry gives e=48 → data_out=0xFFFF_FFFF_FFFF, sat=1. int=63, frac=0x0FFFF → same.
- int=15, frac=0x08000 → 46341 rounded (ANTILOG_ROUND_EN), 46341 truncated (92682>>1 exact). int=2, frac=0x04000 → m=77936, output 4 truncated vs 5 rounded (77936/16384=4.76).
- Back-to-back stream of 30 random codes with out_ready toggled pseudo-randomly → output order and values match a reference model, with no loss or duplication during stalls.
- Reset asserted with 3 codes in flight → next cycle out_valid=0, data_out=0, sat=0; first new code emerges 3 cycles after its accept.
